// File: rtl/paddle_pkg.sv
// Shared definitions for the paddle input conditioner: channel state
// encoding and the debounce constants used for silicon and simulation.
package paddle_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } chan_state_t;

  // 10 ms at 100 MHz
  localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;
  localparam int DEFAULT_CNT_W           = 20;

  // Short window so simulations finish quickly
  localparam int SIM_DEBOUNCE_CYCLES = 4;

endpackage

// File: rtl/debounce_channel.sv
// One paddle button: 2-flop synchroniser, stability counter and a 4-state
// FSM producing a debounced level and a single-cycle trigger per press.
//
// state        | meaning
// IDLE         | button released and stable, level 0
// PRESS_WAIT   | sync high, counting stable high samples, level 0
// PRESSED      | press accepted, level 1, no auto-repeat
// RELEASE_WAIT | sync low, counting stable low samples, level 1
module debounce_channel
  import paddle_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEFAULT_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic trigger,
  output logic level
);

  // A window of one sample accepts the change on the very first stable sample,
  // so the WAIT states are bypassed entirely in that case.
  localparam bit               SINGLE = (DEBOUNCE_CYCLES == 1);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_ff;
  logic             sync;
  logic [CNT_W-1:0] cnt;
  chan_state_t      state;

  assign sync = sync_ff[1];

  // Bring the asynchronous button into the clk domain
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_ff <= 2'b00;
    end else begin
      sync_ff <= {sync_ff[0], btn};
    end
  end

  // Debounce FSM with registered trigger and level
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      trigger <= 1'b0;
      level   <= 1'b0;
    end else begin
      trigger <= 1'b0;
      case (state)
        IDLE: begin
          if (sync) begin
            if (SINGLE) begin
              state   <= PRESSED;
              cnt     <= '0;
              trigger <= 1'b1;
              level   <= 1'b1;
            end else begin
              state <= PRESS_WAIT;
              cnt   <= ONE;
            end
          end else begin
            cnt <= '0;
          end
        end

        PRESS_WAIT: begin
          if (!sync) begin
            // bounce: progress toward acceptance is thrown away
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == LAST) begin
            state   <= PRESSED;
            cnt     <= '0;
            trigger <= 1'b1;
            level   <= 1'b1;
          end else begin
            cnt <= cnt + ONE;
          end
        end

        PRESSED: begin
          if (!sync) begin
            if (SINGLE) begin
              state <= IDLE;
              cnt   <= '0;
              level <= 1'b0;
            end else begin
              state <= RELEASE_WAIT;
              cnt   <= ONE;
            end
          end
        end

        RELEASE_WAIT: begin
          if (sync) begin
            // release glitch: back to held, no new trigger
            state <= PRESSED;
            cnt   <= '0;
          end else if (cnt == LAST) begin
            state <= IDLE;
            cnt   <= '0;
            level <= 1'b0;
          end else begin
            cnt <= cnt + ONE;
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
          level <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/paddle_input_conditioner.sv
// Conditions the right and left paddle buttons into debounced levels and
// one-shot triggers for the ball engine. The two channels are independent;
// simultaneous triggers are passed through unarbitrated.
module paddle_input_conditioner
  import paddle_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEFAULT_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_right,
  input  logic btn_left,
  output logic right_trigger,
  output logic left_trigger,
  output logic right_level,
  output logic left_level
);

  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_right (
    .clk    (clk),
    .reset  (reset),
    .btn    (btn_right),
    .trigger(right_trigger),
    .level  (right_level)
  );

  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_left (
    .clk    (clk),
    .reset  (reset),
    .btn    (btn_left),
    .trigger(left_trigger),
    .level  (left_level)
  );

endmodule

// File: tb/tb_paddle_input_conditioner.sv
// Directed bench for the paddle input conditioner. Each accepted press
// pushes the cycle its trigger is due into a per-channel queue; a monitor
// pops on every observed trigger, so late, early, extra or missing pulses
// all show up as failed comparisons.
module tb_paddle_input_conditioner;
  import paddle_pkg::*;

  localparam int D   = SIM_DEBOUNCE_CYCLES;
  localparam int LAT = D + 2;

  logic clk = 1'b0;
  logic reset;
  logic btn_right;
  logic btn_left;
  logic right_trigger;
  logic left_trigger;
  logic right_level;
  logic left_level;

  int cyc = 0;
  int total = 0;
  int fails = 0;
  int rq[$];
  int lq[$];

  paddle_input_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (20)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_right    (btn_right),
    .btn_left     (btn_left),
    .right_trigger(right_trigger),
    .left_trigger (left_trigger),
    .right_level  (right_level),
    .left_level   (left_level)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string tag, input int obs, input int exp);
    total = total + 1;
    assert (obs === exp)
    else begin
      fails = fails + 1;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Trigger scoreboard, sampled away from the active edge
  always @(negedge clk) begin : mon
    int e;
    if (right_trigger === 1'b1) begin
      if (rq.size() == 0) check("right_unexpected_trigger", cyc, -1);
      else begin
        e = rq.pop_front();
        check("right_trigger_cycle", cyc, e);
      end
    end
    if (left_trigger === 1'b1) begin
      if (lq.size() == 0) check("left_unexpected_trigger", cyc, -1);
      else begin
        e = lq.pop_front();
        check("left_trigger_cycle", cyc, e);
      end
    end
  end

  initial begin
    reset = 1'b1;
    btn_right = 1'b0;
    btn_left = 1'b0;
    @(negedge clk);

    // reset for 3 cycles, outputs all 0
    step(3);
    check("reset_right_trigger", int'(right_trigger), 0);
    check("reset_left_trigger", int'(left_trigger), 0);
    check("reset_right_level", int'(right_level), 0);
    check("reset_left_level", int'(left_level), 0);
    reset = 1'b0;
    step(20);
    check("idle_right_level", int'(right_level), 0);
    check("idle_left_level", int'(left_level), 0);

    // clean right press held 30 cycles
    rq.push_back(cyc + LAT);
    btn_right = 1'b1;
    step(LAT - 1);
    check("right_level_before_accept", int'(right_level), 0);
    step(1);
    check("right_level_at_accept", int'(right_level), 1);
    step(30 - LAT);
    check("right_level_held", int'(right_level), 1);
    check("left_level_untouched", int'(left_level), 0);
    btn_right = 1'b0;
    step(10);
    check("right_level_released", int'(right_level), 0);

    // left bounce 1,0,1,1,0 then final rise held
    btn_left = 1'b1; step(1);
    btn_left = 1'b0; step(1);
    btn_left = 1'b1; step(2);
    btn_left = 1'b0; step(1);
    lq.push_back(cyc + LAT);
    btn_left = 1'b1;
    step(LAT - 1);
    check("left_level_before_accept", int'(left_level), 0);
    step(11 - LAT + 1);
    check("left_level_held", int'(left_level), 1);
    btn_left = 1'b0;
    step(10);
    check("left_level_released", int'(left_level), 0);

    // right press, short release glitch, genuine release, re-press
    rq.push_back(cyc + LAT);
    btn_right = 1'b1;
    step(10);
    btn_right = 1'b0; step(2);
    btn_right = 1'b1; step(8);
    check("right_level_through_glitch", int'(right_level), 1);
    btn_right = 1'b0;
    step(LAT - 1);
    check("right_level_release_pending", int'(right_level), 1);
    step(1);
    check("right_level_release_accept", int'(right_level), 0);
    step(2);
    rq.push_back(cyc + LAT);
    btn_right = 1'b1;
    step(10);
    check("right_level_repress", int'(right_level), 1);
    btn_right = 1'b0;
    step(10);

    // both buttons on the same edge
    rq.push_back(cyc + LAT);
    lq.push_back(cyc + LAT);
    btn_right = 1'b1;
    btn_left = 1'b1;
    step(10);
    check("both_right_level", int'(right_level), 1);
    check("both_left_level", int'(left_level), 1);
    btn_right = 1'b0;
    btn_left = 1'b0;
    step(10);

    // reset mid-PRESS_WAIT with right held: that press is discarded
    btn_right = 1'b1;
    step(4);
    reset = 1'b1;
    step(1);
    check("midreset_right_trigger", int'(right_trigger), 0);
    check("midreset_right_level", int'(right_level), 0);
    step(2);
    check("midreset_right_level_late", int'(right_level), 0);
    rq.push_back(cyc + LAT);
    reset = 1'b0;
    step(LAT - 1);
    check("post_reset_level_pending", int'(right_level), 0);
    step(5);
    check("post_reset_level", int'(right_level), 1);
    btn_right = 1'b0;
    step(10);

    check("right_queue_drained", rq.size(), 0);
    check("left_queue_drained", lq.size(), 0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

  // Hard stop in case the sequence ever stalls
  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/paddle_input_conditioner.md
Name: paddle_input_conditioner

Overview:
Upstream stage of the tennis ball engine. Conditions the two raw paddle push-buttons (left, right): synchronises, debounces and converts each stable press into a single-cycle trigger pulse. Its outputs drive the ball engine's right_trigger/left_trigger inputs directly. One held press yields exactly one trigger.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive stable synchronised samples required to accept a level change (10 ms at 100 MHz); legal range 1..2^CNT_W-1
CNT_W, 20, stability counter width; must hold DEBOUNCE_CYCLES

Ports:
clk  input  1  system clock, single clock domain
reset  input  1  synchronous, active-high reset
btn_right  input  1  raw right paddle button, asynchronous, bouncy, 1 = pressed
btn_left  input  1  raw left paddle button, asynchronous, bouncy, 1 = pressed
right_trigger  output  1  one-cycle pulse per accepted right press
left_trigger  output  1  one-cycle pulse per accepted left press
right_level  output  1  debounced right button level
left_level  output  1  debounced left button level

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset (sampled on the clk rising edge): all synchroniser flops 0, both channels go to IDLE, counters 0, all four outputs 0 on the next cycle.
- Each channel is independent and identical:
  - 2-flop synchroniser, giving sync = input delayed 2 cycles.
  - Stability counter of CNT_W bits.
  - 4-state FSM.
- IDLE (level 0):
  - sync = 1 -> PRESS_WAIT, counter = 1.
  - Otherwise stay, counter = 0.
- PRESS_WAIT (level 0):
  - sync = 0 -> IDLE, counter = 0 (bounce discards progress).
  - sync = 1 and counter = DEBOUNCE_CYCLES-1 -> PRESSED; trigger = 1 for exactly this transition cycle; level goes to 1.
  - Otherwise counter + 1.
- PRESSED (level 1):
  - trigger = 0.
  - sync = 0 -> RELEASE_WAIT, counter = 1. Otherwise stay, with no auto-repeat.
- RELEASE_WAIT (level 1):
  - sync = 1 -> PRESSED, counter = 0, no new trigger.
  - sync = 0 and counter = DEBOUNCE_CYCLES-1 -> IDLE, level goes to 0.
  - Otherwise counter + 1.
- DEBOUNCE_CYCLES = 1: the transition happens on the first stable sample.
- Latency: raw input stable high from clock edge N gives trigger high in the cycle after edge N+1+DEBOUNCE_CYCLES, i.e. DEBOUNCE_CYCLES+2 cycles after the first sampled high. Release latency on level is the same.
- Outputs are registered (driven from FSM/flops, no combinational path from btn_*).
- Counter never wraps: it only counts inside the WAIT states and is bounded by DEBOUNCE_CYCLES-1.
- Simultaneous presses: channels are independent. Both triggers may be high in the same cycle; arbitration is the ball engine's responsibility.
- Reset mid-operation: any in-progress count or pending pulse is discarded. A trigger asserted in the reset cycle is not seen afterwards.
- Button held through reset release: it is treated as a new press and produces one trigger DEBOUNCE_CYCLES+2 cycles after reset deasserts.
- Pulse width is always exactly 1 cycle, and there are no two triggers without an intervening accepted release.

Decomposition:
- Package paddle_pkg holds:
  - the FSM state encoding: IDLE=2'd0, PRESS_WAIT=2'd1, PRESSED=2'd2, RELEASE_WAIT=2'd3;
  - the default DEBOUNCE_CYCLES constant;
  - the simulation constant SIM_DEBOUNCE_CYCLES = 4.
- One sub-module, debounce_channel, contains the synchroniser, counter, FSM, trigger and level for one button. The top level instantiates it twice (right, left) with the same parameters.

Test Plan (DEBOUNCE_CYCLES = 4):
- Reset with btn_right = btn_left = 0 for 3 cycles -> all outputs 0; no trigger within 20 cycles.
- btn_right 0 -> 1 and held 30 cycles -> right_trigger high for exactly 1 cycle, 6 cycles after the first sampled high; right_level = 1 from that cycle; left outputs stay 0.
- btn_left bounces 1,0,1,1,0,1 (one cycle each), then held 1 for 10 cycles -> exactly one left_trigger, 6 cycles after the final rising sample; no pulse during the bounce.
- Press accepted, then a release glitch of 2 cycles of 0 followed by 1 -> right_level stays 1 and no second trigger. A genuine release of 8 cycles -> right_level 0 six cycles after the first 0 sample; re-press -> second trigger.
- Both buttons rise on the same edge and are held -> right_trigger and left_trigger high in the same cycle, 1 cycle each.
- Reset asserted 2 cycles into PRESS_WAIT with btn_right still held -> outputs 0 during reset; after deassertion, one right_trigger 6 cycles later.
